sr_ff_bank: RTL and testbench

Parametrised bank of WIDTH clocked set/reset flip-flops. Each channel resolves the illegal s=r=1 case deterministically through a selectable priority policy; the bank never produces X.
Each channel sets a sticky conflict flag when it sees s=r=1. The bank keeps a saturating count of conflict cycles for debug.
It is the multi-channel successor to the single-bit SR flop and is used wherever grouped status or request bits are set and cleared by independent agents.

---
 rtl/sr_pkg.sv | 34 +++
 rtl/sr_cell.sv | 49 ++++
 rtl/sr_ff_bank.sv | 91 +++++++++
 tb/tb_sr_ff_bank.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared definitions for the SR flip-flop bank.
//   PRI_*   : encodings of the s=r=1 resolution policy.
//   next_q  : next-state of one SR channel for a given policy. Used by the
//             cell RTL so every channel resolves collisions identically.
package sr_pkg;

  localparam int PRI_HOLD = 0;
  localparam int PRI_SET  = 1;
  localparam int PRI_RST  = 2;
  localparam int PRI_TOG  = 3;

  // Next state for one enabled channel. Only 0/1 values are produced from
  // 0/1 inputs, so no policy can introduce X into the register.
  function automatic logic next_q(input logic q, input logic s,
                                  input logic r, input int pri);
    logic res;
    unique case ({s, r})
      2'b00:   res = q;
      2'b01:   res = 1'b0;
      2'b10:   res = 1'b1;
      default: begin
        case (pri)
          PRI_HOLD: res = q;
          PRI_SET:  res = 1'b1;
          PRI_RST:  res = 1'b0;
          PRI_TOG:  res = ~q;
          default:  res = q;
        endcase
      end
    endcase
    return res;
  endfunction

endpackage

// File: rtl/sr_cell.sv
// One SR channel: the state flop plus its sticky conflict flag.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   en         : update enable for q
//   s, r       : set / reset request
//   hit        : this channel saw s=r=1 while enabled (computed by the top)
//   clr_flags  : reload the sticky flag from hit instead of accumulating
//   q          : registered state
//   conflict   : sticky collision flag
module sr_cell
  import sr_pkg::*;
#(
  parameter int   PRIORITY = PRI_SET,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic s,
  input  logic r,
  input  logic hit,
  input  logic clr_flags,
  output logic q,
  output logic conflict
);

  logic q_reg, q_next;
  logic conflict_reg, conflict_next;

  always_comb begin
    q_next = en ? next_q(q_reg, s, r, PRIORITY) : q_reg;
    // A collision in the clearing cycle replaces the old flag, so it is not lost.
    conflict_next = clr_flags ? hit : (conflict_reg | hit);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg        <= RST_VAL;
      conflict_reg <= 1'b0;
    end else begin
      q_reg        <= q_next;
      conflict_reg <= conflict_next;
    end
  end

  assign q        = q_reg;
  assign conflict = conflict_reg;

endmodule

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent clocked SR flip-flops with deterministic
// s=r=1 resolution, sticky per-channel conflict flags and a saturating
// count of cycles in which any channel collided.
// Ports:
//   clk, rst_n     : clock, synchronous active-low reset
//   en             : update enable; 0 holds q and suppresses conflict capture
//   s, r           : per-channel set / reset
//   clr_flags      : clear conflict flags and counter (new hits still land)
//   q, qb          : registered state and its combinational complement
//   conflict       : sticky per-channel collision flags
//   conflict_pulse : one-cycle strobe after any channel collided
//   conflict_cnt   : saturating count of collision cycles
module sr_ff_bank
  import sr_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               PRIORITY = PRI_SET,
  parameter logic [WIDTH-1:0] RST_VAL  = '0,
  parameter int               CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_pulse,
  output logic [CNT_W-1:0] conflict_cnt
);

  if (PRIORITY < PRI_HOLD || PRIORITY > PRI_TOG) begin : g_bad_priority
    $error("sr_ff_bank: PRIORITY must be in 0..3");
  end

  // Collisions only count while enabled.
  logic [WIDTH-1:0] hit;
  logic             any_hit;

  assign hit     = {WIDTH{en}} & s & r;
  assign any_hit = |hit;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
    sr_cell #(
      .PRIORITY (PRIORITY),
      .RST_VAL  (RST_VAL[gi])
    ) u_cell (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .s         (s[gi]),
      .r         (r[gi]),
      .hit       (hit[gi]),
      .clr_flags (clr_flags),
      .q         (q[gi]),
      .conflict  (conflict[gi])
    );
  end

  assign qb = ~q;

  logic             pulse_reg;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Any number of simultaneous channel hits adds exactly one; the count
  // sticks at all-ones rather than wrapping.
  always_comb begin
    cnt_next = cnt_reg;
    if (clr_flags) begin
      cnt_next = any_hit ? CNT_W'(1) : '0;
    end else if (any_hit && cnt_reg != {CNT_W{1'b1}}) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      pulse_reg <= any_hit;
      cnt_reg   <= cnt_next;
    end
  end

  assign conflict_pulse = pulse_reg;
  assign conflict_cnt   = cnt_reg;

endmodule

// File: tb/tb_sr_ff_bank.sv
// Directed bench for sr_ff_bank: four 8-bit instances (one per collision
// policy) plus a 3-bit-counter instance, all driven by the same stimulus.
module tb_sr_ff_bank;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [7:0] s, r;
  logic       clr_flags;

  logic [7:0] q0, q1, q2, q3, qs;
  logic [7:0] qb0, qb1, qb2, qb3, qbs;
  logic [7:0] cf0, cf1, cf2, cf3, cfs;
  logic       pl0, pl1, pl2, pl3, pls;
  logic [7:0] cn0, cn1, cn2, cn3;
  logic [2:0] cns;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sr_ff_bank #(.WIDTH(8), .PRIORITY(0), .RST_VAL(8'hA5), .CNT_W(8)) u_p0 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_flags(clr_flags),
    .q(q0), .qb(qb0), .conflict(cf0), .conflict_pulse(pl0), .conflict_cnt(cn0));
  sr_ff_bank #(.WIDTH(8), .PRIORITY(1), .RST_VAL(8'hA5), .CNT_W(8)) u_p1 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_flags(clr_flags),
    .q(q1), .qb(qb1), .conflict(cf1), .conflict_pulse(pl1), .conflict_cnt(cn1));
  sr_ff_bank #(.WIDTH(8), .PRIORITY(2), .RST_VAL(8'hA5), .CNT_W(8)) u_p2 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_flags(clr_flags),
    .q(q2), .qb(qb2), .conflict(cf2), .conflict_pulse(pl2), .conflict_cnt(cn2));
  sr_ff_bank #(.WIDTH(8), .PRIORITY(3), .RST_VAL(8'hA5), .CNT_W(8)) u_p3 (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_flags(clr_flags),
    .q(q3), .qb(qb3), .conflict(cf3), .conflict_pulse(pl3), .conflict_cnt(cn3));
  sr_ff_bank #(.WIDTH(8), .PRIORITY(1), .RST_VAL(8'hA5), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .r(r), .clr_flags(clr_flags),
    .q(qs), .qb(qbs), .conflict(cfs), .conflict_pulse(pls), .conflict_cnt(cns));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %-14s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %-14s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; s = 8'h00; r = 8'h00; clr_flags = 1'b0;
    #2;
    step();
    check("rst_q",      q1,  8'hA5);
    check("rst_qb",     qb1, 8'h5A);
    check("rst_conf",   cf1, 8'h00);
    check("rst_cnt",    cn1, 8'h00);
    check("rst_pulse",  pl1, 1'b0);

    // Basic update.
    rst_n = 1'b1; en = 1'b1; s = 8'h0F; r = 8'hF0;
    step();
    check("basic_q",    q0,  8'h0F);
    check("basic_qb",   qb3, 8'hF0);
    check("basic_conf", cf1, 8'h00);
    check("basic_pls",  pl1, 1'b0);

    // Policy sweep from q=0F.
    s = 8'hFF; r = 8'hFF;
    step();
    check("pol_hold",   q0,  8'h0F);
    check("pol_set",    q1,  8'hFF);
    check("pol_rst",    q2,  8'h00);
    check("pol_tog",    q3,  8'hF0);
    check("pol_conf0",  cf0, 8'hFF);
    check("pol_conf3",  cf3, 8'hFF);
    check("pol_cnt",    cn2, 8'd1);
    check("pol_pulse",  pl3, 1'b1);

    s = 8'h00; r = 8'h00;
    step();
    check("pulse_drop", pl1, 1'b0);
    check("cnt_hold",   cn1, 8'd1);
    check("tog_hold",   q3,  8'hF0);

    // Enable gating: set requests ignored.
    en = 1'b0; s = 8'hFF; r = 8'h00;
    repeat (3) step();
    check("gate_q",     q2,  8'h00);
    check("gate_cnt",   cn2, 8'd1);

    // Clear flags while disabled, then collisions while disabled.
    clr_flags = 1'b1; s = 8'h00;
    step();
    clr_flags = 1'b0;
    check("clr_conf",   cf1, 8'h00);
    check("clr_cnt",    cn1, 8'd0);
    s = 8'hFF; r = 8'hFF;
    repeat (3) step();
    check("gate_conf",  cf1, 8'h00);
    check("gate_cnt2",  cn1, 8'd0);
    check("gate_pulse", pl1, 1'b0);
    check("gate_tog",   q3,  8'hF0);

    // Saturation: channel 0 collides for 10 cycles.
    en = 1'b1; s = 8'h01; r = 8'h01;
    for (int i = 1; i <= 10; i++) begin
      step();
      check($sformatf("sat_cnt3_%0d", i), cns, (i < 7) ? i : 7);
      check($sformatf("sat_cnt8_%0d", i), cn1, i);
    end
    check("sat_conf",   cf1, 8'h01);
    check("sat_tog",    q3,  8'hF0);
    s = 8'hFF; r = 8'hFF;
    step();
    check("multi_cnt",  cn1, 8'd11);
    check("multi_sat",  cns, 3'd7);

    // Clear with collision: build conflict=03, cnt=5 first.
    en = 1'b0; clr_flags = 1'b1; s = 8'h00; r = 8'h00;
    step();
    en = 1'b1; clr_flags = 1'b0; s = 8'h03; r = 8'h03;
    repeat (5) step();
    check("pre_conf",   cf0, 8'h03);
    check("pre_cnt",    cn0, 8'd5);
    clr_flags = 1'b1; s = 8'h10; r = 8'h10;
    step();
    check("coll_conf",  cf0, 8'h10);
    check("coll_cnt",   cn0, 8'd1);
    check("coll_pulse", pl0, 1'b1);
    s = 8'h00; r = 8'h00;
    step();
    clr_flags = 1'b0;
    check("clr2_conf",  cf0, 8'h00);
    check("clr2_cnt",   cn0, 8'd0);
    check("clr2_q",     q0,  8'h0F);
    check("clr2_pulse", pl0, 1'b0);

    // Mid-operation reset.
    s = 8'hFF; r = 8'hFF;
    repeat (2) step();
    check("acc_cnt",    cn1, 8'd2);
    rst_n = 1'b0;
    step();
    check("mrst_q",     q3,  8'hA5);
    check("mrst_qb",    qb3, 8'h5A);
    check("mrst_conf",  cf3, 8'h00);
    check("mrst_pulse", pl3, 1'b0);
    check("mrst_cnt",   cn3, 8'd0);
    rst_n = 1'b1;
    step();
    check("resume_tog", q3,  8'h5A);
    check("resume_rst", q2,  8'h00);
    check("resume_cnt", cn3, 8'd1);
    check("resume_cf",  cf3, 8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
